rv_gated_dff_cell: RTL and testbench
====================================

Name: rv_gated_dff_cell

Overview:
- Storage primitive for bus bridges and core logic: a clock-gating header plus two flop banks built on it.
- Bank A (capture flop) loads din on every cycle where clken is high.
- Bank B (enable flop) loads din only when en is high, using an internally gated clock.
- A FPGA_OPTIMIZE parameter replaces clock gating with plain clock enables, with identical cycle behaviour.

Parameters:
- WIDTH, 32, bit width of din and of both flop banks (minimum 1).
- FPGA_OPTIMIZE, 0, 1 = no clock gating: l1clk is tied to 0 and the flops use clk with a synchronous enable. 0 = latch-based gated clock.

Ports:
- clk  input  1  single system clock; all flops are posedge clk.
- rst  input  1  reset, asynchronous and active-high; clears all state.
- scan_mode  input  1  test override. When high, the gate is forced open: l1clk toggles and both banks capture every cycle.
- clken  input  1  bus clock enable for bank A.
- en  input  1  load enable for bank B; also drives the exported gate.
- din  input  WIDTH  data into both banks.
- l1clk  output  1  gated clock equal to clk AND latched (en | scan_mode); constant 0 when FPGA_OPTIMIZE=1.
- dff_q  output  WIDTH  bank A contents.
- dffe_q  output  WIDTH  bank B contents.

Behaviour:
- Reset: while rst=1, dff_q=0 and dffe_q=0 immediately, with no clock needed. The gate latch clears to 0, so l1clk=0. Reset overrides all enables.
- Deassertion of rst takes effect at the next posedge clk. No synchronizer is inside this block.
- Clock header (FPGA_OPTIMIZE=0):
  - en_lat is a level latch, transparent while clk=0, capturing en|scan_mode.
  - l1clk = clk & en_lat. This gives glitch-free gating; an enable change while clk=1 affects the next high phase only.
- Bank A: at posedge clk, if (clken | scan_mode), dff_q <= din; otherwise it holds. Latency is 1 cycle.
- Bank B: at posedge clk, if (en | scan_mode), dffe_q <= din; otherwise it holds. Latency is 1 cycle.
- FPGA_OPTIMIZE=0: bank B is clocked by l1clk, with en sampled through the latch.
- FPGA_OPTIMIZE=1: bank B is clocked by clk with a synchronous enable. Observable values at each posedge are identical to the gated build.
- Enable and data change in the same cycle: the flop captures the din present at the enabling edge.
- Back-to-back enables load every cycle. An enable pulse of one cycle loads exactly one value.
- clken=1 and en=0 in the same cycle: only dff_q updates. The banks are fully independent.
- X on en or clken while rst=1 has no effect.
- Widths: no truncation or extension; din maps bit-for-bit to both outputs.
- No combinational path from din to dff_q or dffe_q.
- The l1clk output is for observation and cascading only; it must not feed back into the enable logic.

Test Plan:
- Reset mid-operation: load din=0xDEADBEEF into both banks (clken=1, en=1), then assert rst asynchronously between clock edges. Required: both outputs become 0 before the next edge and stay 0 while rst=1.
- Enable hold: with rst=0 and en=1, din=0x12345678 at edge N, then en=0 and din=0xFFFFFFFF for 5 cycles. Required: dffe_q=0x12345678 from N+1 onward.
- Capture flop independence: clken=1, en=0, din=0x000000A5. Required: dff_q=0xA5 after one edge and dffe_q unchanged. Then clken=0, din=0x5A. Required: dff_q stays 0xA5.
- Scan override: en=0, clken=0, scan_mode=1, din sequence 1, 2, 3. Required: both banks follow with one-cycle latency, and l1clk toggles on every clk period.
- Glitch-free gate (FPGA_OPTIMIZE=0): toggle en while clk=1. Required: l1clk shows no partial pulse, and the change appears on the next high phase.
- Parameter equivalence: run an identical random en/clken/din sequence on WIDTH=8 with FPGA_OPTIMIZE=0 and with FPGA_OPTIMIZE=1. Required: dff_q and dffe_q match cycle for cycle, and l1clk=0 throughout the FPGA_OPTIMIZE=1 build.

Source files
------------

// File: rtl/rv_gated_dff_cell_if.sv
// Bundle of the enable/data inputs and the flop/gated-clock outputs of rv_gated_dff_cell.
// The master drives enables and data; the slave (the cell) returns bank contents and l1clk.
interface rv_gated_dff_cell_if #(
   parameter int WIDTH = 32
);
   logic             scan_mode;
   logic             clken;
   logic             en;
   logic [WIDTH-1:0] din;
   logic             l1clk;
   logic [WIDTH-1:0] dff_q;
   logic [WIDTH-1:0] dffe_q;

   modport master (
      output scan_mode, clken, en, din,
      input  l1clk, dff_q, dffe_q
   );

   modport slave (
      input  scan_mode, clken, en, din,
      output l1clk, dff_q, dffe_q
   );
endinterface

// File: rtl/rv_gated_dff_cell.sv
// Clock-gating header plus two flop banks: bank A loads on clken, bank B on en via a gated clock.
// FPGA_OPTIMIZE swaps the latch-based gate for a plain synchronous enable with identical timing.
module rv_gated_dff_cell #(
   parameter int WIDTH         = 32,
   parameter bit FPGA_OPTIMIZE = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   rv_gated_dff_cell_if.slave   bus
);

   logic             load_a;
   logic             gate_en;
   logic [WIDTH-1:0] dff_r;
   logic [WIDTH-1:0] dffe_r;
   logic             l1clk_w;

   assign load_a  = bus.clken | bus.scan_mode;
   assign gate_en = bus.en | bus.scan_mode;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dff_r <= '0;
      end else if (load_a) begin
         dff_r <= bus.din;
      end
   end

   generate
      if (FPGA_OPTIMIZE) begin : g_fpga
         assign l1clk_w = 1'b0;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               dffe_r <= '0;
            end else if (gate_en) begin
               dffe_r <= bus.din;
            end
         end
      end else begin : g_gated
         logic en_lat;

         // Latch is open only while clk is low, so the gate cannot change during a high phase.
         always_latch begin
            if (rst) begin
               en_lat <= 1'b0;
            end else if (!clk) begin
               en_lat <= gate_en;
            end
         end

         assign l1clk_w = clk & en_lat;

         always_ff @(posedge l1clk_w or posedge rst) begin
            if (rst) begin
               dffe_r <= '0;
            end else begin
               dffe_r <= bus.din;
            end
         end
      end
   endgenerate

   assign bus.l1clk  = l1clk_w;
   assign bus.dff_q  = dff_r;
   assign bus.dffe_q = dffe_r;

endmodule

// File: tb/tb_rv_gated_dff_cell.sv
// Directed bench for rv_gated_dff_cell: 32-bit gated build plus 8-bit gated/FPGA builds side by side.
module tb_rv_gated_dff_cell;

   logic clk;
   logic rst;
   int   check_count = 0;
   int   pass_count  = 0;

   logic       sc8;
   logic       ce8;
   logic       e8;
   logic [7:0] d8;
   logic [7:0] exp_a8;
   logic [7:0] exp_b8;

   rv_gated_dff_cell_if #(.WIDTH(32)) bus32 ();
   rv_gated_dff_cell_if #(.WIDTH(8))  bus_g8 ();
   rv_gated_dff_cell_if #(.WIDTH(8))  bus_f8 ();

   assign bus_g8.scan_mode = sc8;
   assign bus_g8.clken     = ce8;
   assign bus_g8.en        = e8;
   assign bus_g8.din       = d8;
   assign bus_f8.scan_mode = sc8;
   assign bus_f8.clken     = ce8;
   assign bus_f8.en        = e8;
   assign bus_f8.din       = d8;

   rv_gated_dff_cell #(.WIDTH(32), .FPGA_OPTIMIZE(1'b0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus32.slave)
   );

   rv_gated_dff_cell #(.WIDTH(8), .FPGA_OPTIMIZE(1'b0)) dut_g8 (
      .clk (clk),
      .rst (rst),
      .bus (bus_g8.slave)
   );

   rv_gated_dff_cell #(.WIDTH(8), .FPGA_OPTIMIZE(1'b1)) dut_f8 (
      .clk (clk),
      .rst (rst),
      .bus (bus_f8.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout required=finish");
      $fatal(1, "[TB] simulation did not finish");
   end

   task automatic apply_stimulus(input logic sc, input logic ce, input logic e, input logic [31:0] d);
      @(negedge clk);
      bus32.scan_mode = sc;
      bus32.clken     = ce;
      bus32.en        = e;
      bus32.din       = d;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_count++;
      assert (observed === expected) pass_count++;
      else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst             = 1'b1;
      bus32.scan_mode = 1'b0;
      bus32.clken     = 1'b0;
      bus32.en        = 1'b0;
      bus32.din       = '0;
      sc8 = 1'b0; ce8 = 1'b0; e8 = 1'b0; d8 = '0;
      exp_a8 = '0; exp_b8 = '0;

      #3;
      check_output("rst_dff_q",  bus32.dff_q,  32'h0);
      check_output("rst_dffe_q", bus32.dffe_q, 32'h0);
      check_output("rst_l1clk",  {31'b0, bus32.l1clk}, 32'h0);
      check_output("rst_f8_l1clk", {31'b0, bus_f8.l1clk}, 32'h0);

      // X on the enables while reset is held must not disturb the banks
      bus32.en    = 1'bx;
      bus32.clken = 1'bx;
      bus32.din   = 32'hFFFF_FFFF;
      after_edge();
      check_output("xrst_dff_q",  bus32.dff_q,  32'h0);
      check_output("xrst_dffe_q", bus32.dffe_q, 32'h0);
      check_output("xrst_l1clk",  {31'b0, bus32.l1clk}, 32'h0);

      @(negedge clk);
      rst = 1'b0; bus32.en = 1'b0; bus32.clken = 1'b0; bus32.din = '0;

      apply_stimulus(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
      after_edge();
      check_output("load_dff_q",  bus32.dff_q,  32'hDEAD_BEEF);
      check_output("load_dffe_q", bus32.dffe_q, 32'hDEAD_BEEF);
      check_output("load_l1clk",  {31'b0, bus32.l1clk}, 32'h1);
      #2 rst = 1'b1;
      #1;
      check_output("arst_dff_q",  bus32.dff_q,  32'h0);
      check_output("arst_dffe_q", bus32.dffe_q, 32'h0);
      check_output("arst_l1clk",  {31'b0, bus32.l1clk}, 32'h0);
      after_edge();
      check_output("arst_hold_dff_q",  bus32.dff_q,  32'h0);
      check_output("arst_hold_dffe_q", bus32.dffe_q, 32'h0);
      @(negedge clk);
      rst = 1'b0; bus32.en = 1'b0; bus32.clken = 1'b0;

      apply_stimulus(1'b0, 1'b0, 1'b1, 32'h1234_5678);
      after_edge();
      check_output("en_load_dffe_q", bus32.dffe_q, 32'h1234_5678);
      check_output("en_load_dff_q",  bus32.dff_q,  32'h0);
      for (int i = 0; i < 5; i++) begin
         apply_stimulus(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
         after_edge();
         check_output("en_hold_dffe_q", bus32.dffe_q, 32'h1234_5678);
         check_output("en_hold_l1clk",  {31'b0, bus32.l1clk}, 32'h0);
      end

      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0000_00A5);
      after_edge();
      check_output("cap_dff_q",  bus32.dff_q,  32'h0000_00A5);
      check_output("cap_dffe_q", bus32.dffe_q, 32'h1234_5678);
      apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0000_005A);
      after_edge();
      check_output("cap_hold_dff_q",  bus32.dff_q,  32'h0000_00A5);
      check_output("cap_hold_dffe_q", bus32.dffe_q, 32'h1234_5678);

      apply_stimulus(1'b0, 1'b0, 1'b1, 32'hCAFE_0001);
      after_edge();
      check_output("pulse_dffe_q", bus32.dffe_q, 32'hCAFE_0001);
      apply_stimulus(1'b0, 1'b0, 1'b0, 32'hCAFE_0002);
      after_edge();
      check_output("pulse_hold_dffe_q", bus32.dffe_q, 32'hCAFE_0001);
      apply_stimulus(1'b0, 1'b0, 1'b1, 32'h0000_0011);
      after_edge();
      check_output("b2b_first_dffe_q", bus32.dffe_q, 32'h0000_0011);
      apply_stimulus(1'b0, 1'b0, 1'b1, 32'h0000_0022);
      after_edge();
      check_output("b2b_second_dffe_q", bus32.dffe_q, 32'h0000_0022);

      for (int i = 1; i <= 3; i++) begin
         apply_stimulus(1'b1, 1'b0, 1'b0, 32'(i));
         #1;
         check_output("scan_low_l1clk", {31'b0, bus32.l1clk}, 32'h0);
         after_edge();
         check_output("scan_dff_q",  bus32.dff_q,  32'(i));
         check_output("scan_dffe_q", bus32.dffe_q, 32'(i));
         check_output("scan_high_l1clk", {31'b0, bus32.l1clk}, 32'h1);
      end
      apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0000_0077);
      after_edge();
      check_output("scan_off_dff_q",  bus32.dff_q,  32'h3);
      check_output("scan_off_dffe_q", bus32.dffe_q, 32'h3);
      check_output("scan_off_l1clk",  {31'b0, bus32.l1clk}, 32'h0);

      // Enable edges inside a high phase must only show up on the following high phase
      #1 bus32.en = 1'b1;
      #1;
      check_output("gl_rise_same_phase", {31'b0, bus32.l1clk}, 32'h0);
      after_edge();
      check_output("gl_rise_next_phase", {31'b0, bus32.l1clk}, 32'h1);
      check_output("gl_rise_dffe_q", bus32.dffe_q, 32'h0000_0077);
      #2 bus32.en = 1'b0;
      #1;
      check_output("gl_fall_same_phase", {31'b0, bus32.l1clk}, 32'h1);
      @(negedge clk);
      bus32.din = 32'h0000_0088;
      after_edge();
      check_output("gl_fall_next_phase", {31'b0, bus32.l1clk}, 32'h0);
      check_output("gl_fall_dffe_q", bus32.dffe_q, 32'h0000_0077);
      check_output("gl_fall_dff_q",  bus32.dff_q,  32'h3);

      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         sc8 = ($urandom_range(0, 7) == 0);
         ce8 = 1'($urandom_range(0, 1));
         e8  = 1'($urandom_range(0, 1));
         d8  = 8'($urandom);
         if (ce8 | sc8) exp_a8 = d8;
         if (e8 | sc8)  exp_b8 = d8;
         after_edge();
         check_output("eq_g8_dff_q",  {24'b0, bus_g8.dff_q},  {24'b0, exp_a8});
         check_output("eq_g8_dffe_q", {24'b0, bus_g8.dffe_q}, {24'b0, exp_b8});
         check_output("eq_f8_dff_q",  {24'b0, bus_f8.dff_q},  {24'b0, exp_a8});
         check_output("eq_f8_dffe_q", {24'b0, bus_f8.dffe_q}, {24'b0, exp_b8});
         check_output("eq_g8_l1clk",  {31'b0, bus_g8.l1clk},  {31'b0, e8 | sc8});
         check_output("eq_f8_l1clk",  {31'b0, bus_f8.l1clk},  32'h0);
      end

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
